// File: rtl/mxint_pkg.sv
// Shared types and helpers for the MxInt-to-fixed conversion path.
package mxint_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   function automatic int ebias(input int exp_width);
      return (1 << (exp_width - 1)) - 1;
   endfunction

   function automatic int sat_max(input int width);
      return (1 << (width - 1)) - 1;
   endfunction

endpackage

// File: rtl/mxint_elem_to_fixed.sv
// Combinational converter: one signed mantissa scaled by 2^shift into a
// symmetric-saturated signed fixed-point value.
module mxint_elem_to_fixed
   import mxint_pkg::*;
#(
   parameter int MAN_WIDTH   = 8,
   parameter int OUT_WIDTH   = 16,
   parameter int SHIFT_WIDTH = 10
) (
   input  logic signed [MAN_WIDTH-1:0]   i_man,
   input  logic signed [SHIFT_WIDTH-1:0] i_shift,
   output logic signed [OUT_WIDTH-1:0]   o_fixed
);

   localparam int WW = MAN_WIDTH + OUT_WIDTH;
   localparam logic signed [OUT_WIDTH-1:0]   MAXO      = OUT_WIDTH'(sat_max(OUT_WIDTH));
   localparam logic signed [WW-1:0]          MAXW      = WW'(sat_max(OUT_WIDTH));
   localparam logic signed [WW-1:0]          NEGW      = -MAXW;
   localparam logic signed [SHIFT_WIDTH-1:0] SAT_SHIFT = SHIFT_WIDTH'(OUT_WIDTH);

   logic signed [WW-1:0]          w_ext;
   logic signed [WW-1:0]          w_wide;
   logic        [SHIFT_WIDTH-1:0] w_neg;

   // The wide intermediate holds |m| * 2^(OUT_WIDTH-1) without overflow, so
   // saturation is a plain range compare once large shifts are excluded.
   always_comb begin
      w_ext   = {{OUT_WIDTH{i_man[MAN_WIDTH-1]}}, i_man};
      w_neg   = SHIFT_WIDTH'(-i_shift);
      w_wide  = '0;
      o_fixed = '0;
      if (i_man != '0) begin
         if (i_shift >= SAT_SHIFT) begin
            o_fixed = i_man[MAN_WIDTH-1] ? -MAXO : MAXO;
         end else begin
            if (i_shift[SHIFT_WIDTH-1]) w_wide = w_ext >>> w_neg;
            else                        w_wide = w_ext <<< i_shift;
            if (w_wide > MAXW)      o_fixed = MAXO;
            else if (w_wide < NEGW) o_fixed = -MAXO;
            else                    o_fixed = OUT_WIDTH'(w_wide);
         end
      end
   end

endmodule

// File: rtl/mxint_to_fixed_serializer.sv
// Accepts one MxInt block (mantissas + shared exponent) per handshake and
// streams it out as NUM_BEATS beats of OUT_SIZE fixed-point values.
module mxint_to_fixed_serializer
   import mxint_pkg::*;
#(
   parameter int MAN_WIDTH      = 8,
   parameter int EXP_WIDTH      = 8,
   parameter int BLOCK_SIZE     = 16,
   parameter int OUT_SIZE       = 4,
   parameter int OUT_WIDTH      = 16,
   parameter int OUT_FRAC_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [MAN_WIDTH-1:0] mdata_in [BLOCK_SIZE],
   input  logic        [EXP_WIDTH-1:0] edata_in,
   input  logic                        data_in_valid,
   output logic                        data_in_ready,
   output logic signed [OUT_WIDTH-1:0] data_out [OUT_SIZE],
   output logic                        data_out_valid,
   input  logic                        data_out_ready,
   output logic                        data_out_last
);

   localparam int NUM_BEATS = BLOCK_SIZE / OUT_SIZE;
   localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int IDX_W     = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int CLOG_MO   = $clog2(MAN_WIDTH + OUT_WIDTH);
   localparam int SHW       = ((EXP_WIDTH > CLOG_MO) ? EXP_WIDTH : CLOG_MO) + 2;
   localparam int SHIFT_OFF = OUT_FRAC_WIDTH + 2 - MAN_WIDTH - ebias(EXP_WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

   state_t                      r_state;
   state_t                      w_next;
   logic        [CNT_W-1:0]     r_cnt;
   logic signed [MAN_WIDTH-1:0] r_man [BLOCK_SIZE];
   logic signed [SHW-1:0]       r_shift;
   logic signed [SHW-1:0]       w_shift_in;
   logic signed [MAN_WIDTH-1:0] w_sel_man [OUT_SIZE];
   logic                        w_at_last;
   logic                        w_capture;
   logic                        w_advance;

   assign w_shift_in = SHW'(edata_in) + SHW'(SHIFT_OFF);
   assign w_at_last  = (r_cnt == LAST_CNT);

   always_comb begin
      w_next         = r_state;
      w_capture      = 1'b0;
      w_advance      = 1'b0;
      data_in_ready  = 1'b0;
      data_out_valid = 1'b0;
      data_out_last  = 1'b0;
      case (r_state)
         IDLE: begin
            data_in_ready = 1'b1;
            if (data_in_valid) begin
               w_capture = 1'b1;
               w_next    = SEND;
            end
         end
         SEND: begin
            data_out_valid = 1'b1;
            data_out_last  = w_at_last;
            if (data_out_ready) begin
               // Reloading on the last beat keeps back-to-back blocks bubble-free.
               if (w_at_last) begin
                  data_in_ready = 1'b1;
                  if (data_in_valid) w_capture = 1'b1;
                  else               w_next    = IDLE;
               end else begin
                  w_advance = 1'b1;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         for (int unsigned i = 0; i < BLOCK_SIZE; i++) r_man[i] <= '0;
      end else begin
         r_state <= w_next;
         if (w_capture) begin
            r_man   <= mdata_in;
            r_shift <= w_shift_in;
            r_cnt   <= '0;
         end else if (w_advance) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      for (int unsigned j = 0; j < OUT_SIZE; j++)
         w_sel_man[j] = r_man[IDX_W'(32'(r_cnt) * OUT_SIZE + j)];
   end

   for (genvar g = 0; g < OUT_SIZE; g++) begin : g_elem
      mxint_elem_to_fixed #(
         .MAN_WIDTH   (MAN_WIDTH),
         .OUT_WIDTH   (OUT_WIDTH),
         .SHIFT_WIDTH (SHW)
      ) u_elem (
         .i_man   (w_sel_man[g]),
         .i_shift (r_shift),
         .o_fixed (data_out[g])
      );
   end

endmodule
